vco_freq_cal: RTL and testbench

- Digital calibration controller for the voltage-controlled oscillator.
- Drives the VCO tuning DAC code and counts squared VCO output edges over a reference-clock gate window.
- Runs a successive-approximation (SAR) search so the measured count converges on a programmed target, i.e. the oscillator lands on a requested frequency.
- Sits between the host/config logic (start, target, timing) and the mixed-signal DAC feeding the VCO control voltage (vin).

---
 rtl/vco_freq_cal_pkg.sv | 17 +
 rtl/vco_freq_cal_if.sv | 28 ++
 rtl/vco_freq_cal_edge_counter.sv | 39 +++
 rtl/vco_freq_cal.sv | 161 ++++++++++++++++
 tb/tb_vco_freq_cal.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vco_freq_cal_pkg.sv
// Shared types and helpers for the VCO frequency calibration controller.
package vco_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        DONE
    } state_e;

    // Mid-scale DAC code: 0 V control, VCO centre frequency.
    function automatic int unsigned mid_code(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/vco_freq_cal_if.sv
// Host/config side of the calibration controller: start, targets, results.
interface vco_freq_cal_if #(
    parameter int DAC_W    = 8,
    parameter int CNT_W    = 16,
    parameter int GATE_W   = 16,
    parameter int SETTLE_W = 8
);
    logic                start;
    logic [CNT_W-1:0]    target_cnt;
    logic [GATE_W-1:0]   gate_cycles;
    logic [SETTLE_W-1:0] settle_cycles;
    logic [DAC_W-1:0]    dac_code;
    logic                busy;
    logic                done;
    logic                locked;
    logic                rail;
    logic [CNT_W-1:0]    meas_cnt;

    modport master (
        output start, target_cnt, gate_cycles, settle_cycles,
        input  dac_code, busy, done, locked, rail, meas_cnt
    );

    modport slave (
        input  start, target_cnt, gate_cycles, settle_cycles,
        output dac_code, busy, done, locked, rail, meas_cnt
    );
endinterface

// File: rtl/vco_freq_cal_edge_counter.sv
// Synchronises the squared VCO output and counts its rising edges,
// saturating at all-ones. Only meaningful for f_vco < f_clk/2.
module vco_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vco_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    always_comb begin
        // [0],[1] form the synchroniser; [2] is the previous synchronised sample.
        sync_d = {sync_q[1:0], vco_in};
        rise   = sync_q[1] & ~sync_q[2];
        cnt_d  = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && rise && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/vco_freq_cal.sv
// SAR calibration of the VCO tuning DAC: DAC_W search passes plus one
// verification pass, each a settle delay followed by a gated edge count.
module vco_freq_cal
    import vco_cal_pkg::*;
#(
    parameter int DAC_W    = 8,
    parameter int CNT_W    = 16,
    parameter int GATE_W   = 16,
    parameter int SETTLE_W = 8,
    parameter int TOL      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vco_in,
    vco_freq_cal_if.slave cal
);
    localparam int BIT_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;
    localparam int TMR_W = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;
    localparam logic [DAC_W-1:0] MID = DAC_W'(mid_code(DAC_W));

    state_e              state_q, state_d;
    logic [DAC_W-1:0]    dac_q, dac_d, trial;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                final_q, final_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                locked_q, locked_d, rail_q, rail_d;
    logic [CNT_W-1:0]    meas_q, meas_d, target_q, target_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d, meas_last;
    logic [CNT_W-1:0]    cnt;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]      adiff;
    logic                in_tol;

    vco_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .vco_in (vco_in),
        .clr    (state_q == SETTLE),
        .en     (state_q == MEASURE),
        .cnt    (cnt)
    );

    // Gate length 0 behaves as a single-cycle window.
    assign meas_last = (gate_q == '0) ? '0 : TMR_W'(gate_q - GATE_W'(1));
    assign diff      = $signed({1'b0, cnt}) - $signed({1'b0, target_q});
    assign adiff     = diff[CNT_W] ? (CNT_W+1)'(-diff) : (CNT_W+1)'(diff);
    assign in_tol    = adiff <= (CNT_W+1)'(TOL);

    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        bit_d    = bit_q;
        final_d  = final_q;
        busy_d   = busy_q;
        done_d   = done_q;
        locked_d = locked_q;
        rail_d   = rail_q;
        meas_d   = meas_q;
        target_d = target_q;
        gate_d   = gate_q;
        settle_d = settle_q;
        tmr_d    = tmr_q;
        trial    = dac_q;
        case (state_q)
            IDLE, DONE: begin
                if (cal.start) begin
                    target_d = cal.target_cnt;
                    gate_d   = cal.gate_cycles;
                    settle_d = cal.settle_cycles;
                    dac_d    = MID;
                    bit_d    = BIT_W'(DAC_W - 1);
                    final_d  = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    locked_d = 1'b0;
                    rail_d   = 1'b0;
                    tmr_d    = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TMR_W'(settle_q)) begin
                    tmr_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == meas_last) begin
                    tmr_d   = '0;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                meas_d = cnt;
                if (final_q) begin
                    locked_d = in_tol;
                    rail_d   = !in_tol && ((dac_q == '0) || (dac_q == '1));
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    // Positive gain: too fast (or on target) means drop this bit.
                    if (cnt >= target_q)
                        trial[bit_q] = 1'b0;
                    if (bit_q != '0) begin
                        trial[bit_q - BIT_W'(1)] = 1'b1;
                        bit_d = bit_q - BIT_W'(1);
                    end else begin
                        final_d = 1'b1;
                    end
                    dac_d   = trial;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dac_q    <= MID;
            bit_q    <= '0;
            final_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            rail_q   <= 1'b0;
            meas_q   <= '0;
            target_q <= '0;
            gate_q   <= '0;
            settle_q <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            bit_q    <= bit_d;
            final_q  <= final_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            rail_q   <= rail_d;
            meas_q   <= meas_d;
            target_q <= target_d;
            gate_q   <= gate_d;
            settle_q <= settle_d;
            tmr_q    <= tmr_d;
        end
    end

    assign cal.dac_code = dac_q;
    assign cal.busy     = busy_q;
    assign cal.done     = done_q;
    assign cal.locked   = locked_q;
    assign cal.rail     = rail_q;
    assign cal.meas_cnt = meas_q;
endmodule

// File: tb/tb_vco_freq_cal.sv
// Directed checks of the VCO calibration controller against a linear VCO
// model (edges per 1000 cycles = 2*code + offset) and a clk/3 source.
module tb_vco_freq_cal;
    logic clk, rst_n, vco_a, vco_b;
    int   n_chk, n_fail, off, acc, inc, ph, ncyc;

    vco_freq_cal_if cal ();
    vco_freq_cal_if #(.CNT_W(8)) sif ();

    vco_freq_cal dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vco_in (vco_a),
        .cal    (cal)
    );

    vco_freq_cal #(.CNT_W(8)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .vco_in (vco_b),
        .cal    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Linear VCO: a wrap of the phase accumulator is one rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc   = 0;
            vco_a = 1'b0;
        end else begin
            inc = 2 * int'(cal.dac_code) + off;
            if (acc + inc >= 1000) begin
                acc   = acc + inc - 1000;
                vco_a = 1'b1;
            end else begin
                acc   = acc + inc;
                vco_a = 1'b0;
            end
        end
    end

    // Fixed source at clk/3 for the saturation instance.
    always @(negedge clk) begin
        ph    = (ph == 2) ? 0 : ph + 1;
        vco_b = (ph == 0);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called #1 after a posedge. bump_at pulses start (and a new target)
    // mid-run; rst_at asserts reset mid-run and returns.
    task automatic run_cal(input logic [15:0] tgt, input logic [15:0] gate, input logic [7:0] stl,
                           input int offs, input int bump_at, input int rst_at, output int cyc);
        off               = offs;
        cal.target_cnt    = tgt;
        cal.gate_cycles   = gate;
        cal.settle_cycles = stl;
        cal.start         = 1'b1;
        @(posedge clk); #1;
        cal.start = 1'b0;
        cyc = 0;
        chk("busy_after_start", {31'd0, cal.busy}, 32'd1);
        chk("done_cleared", {31'd0, cal.done}, 32'd0);
        while (!cal.done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            cal.start = (cyc == bump_at);
            if (cyc == bump_at) cal.target_cnt = 16'd600;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_dac", {24'd0, cal.dac_code}, 32'h80);
                chk("rst_busy", {31'd0, cal.busy}, 32'd0);
                chk("rst_done", {31'd0, cal.done}, 32'd0);
                chk("rst_locked", {31'd0, cal.locked}, 32'd0);
                chk("rst_rail", {31'd0, cal.rail}, 32'd0);
                chk("rst_meas", {16'd0, cal.meas_cnt}, 32'd0);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_seen", {31'd0, cal.done}, 32'd1);
        chk("busy_end", {31'd0, cal.busy}, 32'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; off = 0; acc = 0; ph = 0;
        vco_a = 1'b0; vco_b = 1'b0;
        rst_n = 1'b0;
        cal.start = 1'b0; cal.target_cnt = '0; cal.gate_cycles = '0; cal.settle_cycles = '0;
        sif.start = 1'b0; sif.target_cnt = '0; sif.gate_cycles = '0; sif.settle_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dac", {24'd0, cal.dac_code}, 32'h80);
        chk("reset_busy", {31'd0, cal.busy}, 32'd0);
        chk("reset_done", {31'd0, cal.done}, 32'd0);
        chk("reset_locked", {31'd0, cal.locked}, 32'd0);
        chk("reset_rail", {31'd0, cal.rail}, 32'd0);
        chk("reset_meas", {16'd0, cal.meas_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Target 300: 0x95 is the largest code with 2*code < 300; verify 298.
        run_cal(16'd300, 16'd1000, 8'd4, 0, -1, -1, ncyc);
        chk("t300_cycles", ncyc, 32'd9054);
        chk("t300_dac", {24'd0, cal.dac_code}, 32'h95);
        chk("t300_meas", {16'd0, cal.meas_cnt}, 32'd298);
        chk("t300_locked", {31'd0, cal.locked}, 32'd1);
        chk("t300_rail", {31'd0, cal.rail}, 32'd0);

        run_cal(16'd600, 16'd1000, 8'd4, 0, -1, -1, ncyc);
        chk("t600_dac", {24'd0, cal.dac_code}, 32'hFF);
        chk("t600_locked", {31'd0, cal.locked}, 32'd0);
        chk("t600_rail", {31'd0, cal.rail}, 32'd1);

        run_cal(16'd0, 16'd1000, 8'd4, 0, -1, -1, ncyc);
        chk("t0_dac", {24'd0, cal.dac_code}, 32'h00);
        chk("t0_meas", {16'd0, cal.meas_cnt}, 32'd0);
        chk("t0_locked", {31'd0, cal.locked}, 32'd1);
        chk("t0_rail", {31'd0, cal.rail}, 32'd0);

        run_cal(16'd0, 16'd1000, 8'd4, 10, -1, -1, ncyc);
        chk("t0off_dac", {24'd0, cal.dac_code}, 32'h00);
        chk("t0off_meas", {16'd0, cal.meas_cnt}, 32'd10);
        chk("t0off_locked", {31'd0, cal.locked}, 32'd0);
        chk("t0off_rail", {31'd0, cal.rail}, 32'd1);

        // Reset during pass 4, then a clean full calibration.
        run_cal(16'd300, 16'd1000, 8'd4, 0, -1, 3500, ncyc);
        run_cal(16'd300, 16'd1000, 8'd4, 0, -1, -1, ncyc);
        chk("post_rst_cycles", ncyc, 32'd9054);
        chk("post_rst_dac", {24'd0, cal.dac_code}, 32'h95);
        chk("post_rst_locked", {31'd0, cal.locked}, 32'd1);

        // Start (with a different target) while busy must be ignored.
        run_cal(16'd300, 16'd1000, 8'd4, 0, 2000, -1, ncyc);
        chk("bump_cycles", ncyc, 32'd9054);
        chk("bump_dac", {24'd0, cal.dac_code}, 32'h95);
        chk("bump_meas", {16'd0, cal.meas_cnt}, 32'd298);

        // Zero gate and settle: 3-cycle passes.
        run_cal(16'd0, 16'd0, 8'd0, 0, -1, -1, ncyc);
        chk("gate0_cycles", ncyc, 32'd27);
        chk("gate0_dac", {24'd0, cal.dac_code}, 32'h00);
        chk("gate0_locked", {31'd0, cal.locked}, 32'd1);

        // 8-bit counter with ~666 edges per window saturates at 0xFF.
        sif.target_cnt    = 8'd100;
        sif.gate_cycles   = 16'd2000;
        sif.settle_cycles = 8'd4;
        sif.start         = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        ncyc = 0;
        while (!sif.done && ncyc < 25000) begin
            @(posedge clk); #1;
            ncyc++;
        end
        chk("sat_done", {31'd0, sif.done}, 32'd1);
        chk("sat_cycles", ncyc, 32'd18054);
        chk("sat_meas", {24'd0, sif.meas_cnt}, 32'hFF);
        chk("sat_dac", {24'd0, sif.dac_code}, 32'h00);
        chk("sat_locked", {31'd0, sif.locked}, 32'd0);
        chk("sat_rail", {31'd0, sif.rail}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
